// File: rtl/bus_tx_queue.sv
// Buffered bus source: a small FIFO feeding a 74244-style 3-state buffer, sequencing its
// active-low enables so every word gets a setup cycle, a fixed hold window and a dead turnaround.
module bus_tx_queue #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   bus_grant,
  output logic                   bus_req,
  output logic [WIDTH-1:0]       A,
  output logic [(WIDTH-1)/4:0]   G_bar,
  output logic                   sent,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned GW   = (WIDTH - 1) / 4 + 1;
  localparam int unsigned MAXC = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
  localparam int unsigned KW   = $clog2(MAXC + 1);

  localparam logic [KW-1:0] HoldLast = KW'(HOLD_CYCLES - 1);
  localparam logic [KW-1:0] TurnLast = KW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StDrive, StTurn} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q;
  logic [GW-1:0]    g_bar_q;
  logic             push, pop, load_a;

  // No bypass: a pop on the same edge does not free a slot for a push when full.
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = sent;
  assign bus_req  = (count_q != '0) || (state_q != StIdle);
  assign count    = count_q;
  assign A        = a_q;
  assign G_bar    = g_bar_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sent    = 1'b0;
    load_a  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && bus_grant) begin
          state_d = StSetup;
          load_a  = 1'b1;
        end
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = bus_grant ? StDrive : StTurn;
      end
      StDrive: begin
        if (!bus_grant) begin
          // Abort: word stays queued and is retried from SETUP later.
          state_d = StTurn;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          sent    = 1'b1;
          state_d = StTurn;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StTurn: begin
        if (cnt_q == TurnLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      a_q      <= '0;
      g_bar_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (load_a) begin
        a_q <= mem_q[rd_ptr_q];
      end
      g_bar_q <= (state_d == StDrive) ? '0 : '1;
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_bus_tx_queue.sv
// Scoreboard bench for bus_tx_queue: default 8-bit instance plus a 16-bit, hold 3, turn 2 instance.
module tb_bus_tx_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  in_data  = '0;
  logic        in_valid = 1'b0;
  logic        grant    = 1'b1;
  logic        in_ready, bus_req, sent;
  logic [7:0]  A;
  logic [1:0]  G_bar;
  logic [2:0]  count;

  logic [15:0] in_data2  = '0;
  logic        in_valid2 = 1'b0;
  logic        grant2    = 1'b1;
  logic        in_ready2, bus_req2, sent2;
  logic [15:0] A2;
  logic [3:0]  G2;
  logic [2:0]  count2;

  int          n_checks = 0;
  int          n_errors = 0;
  int          sent_cnt = 0;
  int          sent_cnt2 = 0;
  logic [7:0]  sb[$];
  logic [15:0] sb2[$];

  always #5 clk = ~clk;

  bus_tx_queue dut (
    .clk(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bus_grant(grant), .bus_req(bus_req), .A(A), .G_bar(G_bar), .sent(sent), .count(count)
  );

  bus_tx_queue #(.WIDTH(16), .DEPTH(4), .HOLD_CYCLES(3), .TURN_CYCLES(2)) dut2 (
    .clk(clk), .reset(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .bus_grant(grant2), .bus_req(bus_req2), .A(A2), .G_bar(G2), .sent(sent2), .count(count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] d, input logic acc);
    in_data  = d;
    in_valid = 1'b1;
    check("in_ready", 32'(in_ready), 32'(acc));
    if (acc) sb.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain1(input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus_req) && n < budget) begin
      tick();
      n++;
    end
    check("drain1", 32'(sb.size() == 0 && !bus_req), 32'h1);
  endtask

  // Monitor for the default instance: data order, enable during sent, turnaround, A stability.
  logic       sent_prev = 1'b0;
  logic [1:0] g_prev = 2'b11;
  logic [7:0] a_prev = '0;
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (sent) begin
        sent_cnt++;
        check("sent_gbar", 32'(G_bar), 32'h0);
        check("sb_has_entry", 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sent_data", 32'(A), 32'(e));
        end
      end
      if (sent_prev) check("turn_gap", 32'(G_bar), 32'h3);
      if (G_bar == 2'b00 && g_prev == 2'b00) check("a_stable", 32'(A), 32'(a_prev));
      sent_prev = sent;
      g_prev    = G_bar;
      a_prev    = A;
    end else begin
      sent_prev = 1'b0;
      g_prev    = 2'b11;
    end
  end

  // Monitor for the wide instance: hold length, word period, A stability, data order.
  logic [3:0]  g2_prev = 4'hf;
  logic [15:0] a2_prev = '0;
  int          low_run2 = 0;
  int          since_fall2 = 0;
  int          nfalls2 = 0;
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst) begin
      if (sent2) begin
        sent_cnt2++;
        check("sb2_has_entry", 32'(sb2.size() != 0), 32'h1);
        if (sb2.size() != 0) begin
          e = sb2.pop_front();
          check("sent2_data", 32'(A2), 32'(e));
        end
      end
      if (G2 == 4'h0) begin
        low_run2++;
        if (g2_prev != 4'h0) begin
          if (nfalls2 > 0) check("period2", 32'(since_fall2), 32'd7);
          since_fall2 = 0;
          nfalls2++;
        end else begin
          check("a2_stable", 32'(A2), 32'(a2_prev));
        end
      end else if (g2_prev == 4'h0) begin
        check("hold2", 32'(low_run2), 32'd3);
        low_run2 = 0;
      end
      since_fall2++;
      g2_prev = G2;
      a2_prev = A2;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    repeat (2) tick();
    check("rst_gbar", 32'(G_bar), 32'h3);
    check("rst_a", 32'(A), 32'h0);
    check("rst_sent", 32'(sent), 32'h0);
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_count", 32'(count), 32'h0);
    rst = 1'b0;
    tick();

    // 1: single word latency and shape
    push1(8'hA5, 1'b1);
    check("t1_count", 32'(count), 32'h1);
    check("t1_req", 32'(bus_req), 32'h1);
    tick();
    check("t1_setup_a", 32'(A), 32'hA5);
    check("t1_setup_g", 32'(G_bar), 32'h3);
    tick();
    check("t1_drive1_g", 32'(G_bar), 32'h0);
    check("t1_drive1_sent", 32'(sent), 32'h0);
    tick();
    check("t1_drive2_g", 32'(G_bar), 32'h0);
    check("t1_drive2_sent", 32'(sent), 32'h1);
    tick();
    check("t1_turn_g", 32'(G_bar), 32'h3);
    check("t1_turn_count", 32'(count), 32'h0);
    tick();
    check("t1_idle_req", 32'(bus_req), 32'h0);

    // 2: fill with grant low, fifth word refused, then drain in order
    grant = 1'b0;
    base = sent_cnt;
    for (int i = 1; i <= 5; i++) push1(8'(i), (i <= 4));
    check("t2_count", 32'(count), 32'h4);
    check("t2_full_ready", 32'(in_ready), 32'h0);
    check("t2_gbar_nogrant", 32'(G_bar), 32'h3);
    grant = 1'b1;
    drain1(60);
    check("t2_sent_cnt", 32'(sent_cnt - base), 32'd4);

    // 3: grant lost in first DRIVE cycle, then full retry
    base = sent_cnt;
    push1(8'h3C, 1'b1);
    tick();
    tick();
    check("t3_drive_g", 32'(G_bar), 32'h0);
    grant = 1'b0;
    check("t3_abort_sent", 32'(sent), 32'h0);
    tick();
    check("t3_abort_g", 32'(G_bar), 32'h3);
    check("t3_abort_count", 32'(count), 32'h1);
    repeat (3) tick();
    check("t3_wait_count", 32'(count), 32'h1);
    check("t3_wait_g", 32'(G_bar), 32'h3);
    check("t3_no_sent", 32'(sent_cnt - base), 32'd0);
    grant = 1'b1;
    tick();
    check("t3_retry_setup_a", 32'(A), 32'h3C);
    check("t3_retry_setup_g", 32'(G_bar), 32'h3);
    tick();
    check("t3_retry_d1", 32'(G_bar), 32'h0);
    tick();
    check("t3_retry_d2", 32'(G_bar), 32'h0);
    check("t3_retry_sent", 32'(sent), 32'h1);
    tick();
    check("t3_retry_count", 32'(count), 32'h0);
    check("t3_sent_cnt", 32'(sent_cnt - base), 32'd1);
    drain1(20);

    // 4: push against a full FIFO on the popping edge is refused
    grant = 1'b0;
    for (int i = 0; i < 4; i++) push1(8'hB0 + 8'(i), 1'b1);
    check("t4_full", 32'(count), 32'h4);
    grant = 1'b1;
    tick();
    tick();
    tick();
    in_data  = 8'hB4;
    in_valid = 1'b1;
    check("t4_pop_sent", 32'(sent), 32'h1);
    check("t4_pop_ready", 32'(in_ready), 32'h0);
    tick();
    check("t4_after_pop_count", 32'(count), 32'h3);
    check("t4_after_pop_ready", 32'(in_ready), 32'h1);
    sb.push_back(8'hB4);
    tick();
    in_valid = 1'b0;
    check("t4_refill_count", 32'(count), 32'h4);
    drain1(60);

    // 5: asynchronous reset in the middle of DRIVE
    base = sent_cnt;
    push1(8'h5A, 1'b1);
    tick();
    tick();
    check("t5_drive_g", 32'(G_bar), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_g", 32'(G_bar), 32'h3);
    check("t5_async_req", 32'(bus_req), 32'h0);
    check("t5_async_count", 32'(count), 32'h0);
    sb.delete();
    #4;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_idle_g", 32'(G_bar), 32'h3);
    end
    check("t5_count", 32'(count), 32'h0);
    check("t5_no_sent", 32'(sent_cnt - base), 32'd0);

    // 6: wide instance, two words back to back
    in_data2  = 16'h1234;
    in_valid2 = 1'b1;
    check("t6_ready_a", 32'(in_ready2), 32'h1);
    sb2.push_back(16'h1234);
    tick();
    in_data2 = 16'hBEEF;
    check("t6_ready_b", 32'(in_ready2), 32'h1);
    sb2.push_back(16'hBEEF);
    tick();
    in_valid2 = 1'b0;
    n = 0;
    while ((sb2.size() != 0 || bus_req2) && n < 40) begin
      tick();
      n++;
    end
    check("drain2", 32'(sb2.size() == 0 && !bus_req2), 32'h1);
    check("t6_falls", 32'(nfalls2), 32'd2);
    check("t6_sent_cnt", 32'(sent_cnt2), 32'd2);
    check("t6_count", 32'(count2), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
